// File: rtl/dff.sv
// dff: parameterised-width D flip-flop with asynchronous active-low reset.
// Basic storage element of the design library. Q comes straight from the
// register, so no combinational path exists from D to Q. While _rst is low,
// Q is forced to RST_VAL and clock edges and D are ignored. After _rst
// rises, Q keeps RST_VAL until the next rising clk edge.
module dff #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         _rst,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q
);

  // Capture the whole word on each rising clk edge. Reset is in the
  // sensitivity list, so pulling _rst low forces RST_VAL at once, with no
  // clock edge needed. If _rst is low at a clk edge, reset wins.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      Q <= RST_VAL;
    end else begin
      Q <= D;
    end
  end

endmodule

// File: tb/tb_dff.sv
// tb_dff: directed-vector bench for dff.
// Two instances share one clock:
// - a 1-bit instance with the default reset value;
// - an 8-bit instance that resets to 8'hA5.
// The clock period is 20 ns, with rising edges at 10, 30, 50 ns and so on.
// Outputs are sampled 1 ns after an edge or at mid-cycle, never on an edge.
`timescale 1ns/1ps
module tb_dff;

  logic       clk;
  logic       rstN;
  logic       d;
  logic       q;
  logic       wRstN;
  logic [7:0] wD;
  logic [7:0] wQ;

  int assertCount;
  int failCount;

  dff #(.W(1)) dutNarrow (
    .clk  (clk),
    ._rst (rstN),
    .D    (d),
    .Q    (q)
  );

  dff #(.W(8), .RST_VAL(8'hA5)) dutWide (
    .clk  (clk),
    ._rst (wRstN),
    .D    (wD),
    .Q    (wQ)
  );

  // Free-running clock: low at t = 0, first rising edge at 10 ns.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Count one comparison and report it if the observed value differs from
  // the expected one.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h",
               tag, $time, observed, expected);
    end
  endtask

  // Advance simulation to an absolute time in ns.
  task automatic waitUntil(input int t);
    if (t > $time) #(t - $time);
  endtask

  // Directed sequence. The expected values come from the timeline in the
  // comments: Q after edge n equals D just before edge n.
  initial begin
    assertCount = 0;
    failCount   = 0;
    rstN  = 1'b1;
    wRstN = 1'b1;
    d     = 1'b0;
    wD    = 8'h00;

    // Assert both resets between edges. Q must respond with no clock edge.
    waitUntil(1);
    rstN  = 1'b0;
    wRstN = 1'b0;
    waitUntil(2);
    checkOutput("narrow_reset_async", {7'b0, q}, 8'h00);
    checkOutput("wide_reset_async", wQ, 8'hA5);

    // Toggle D during reset. The 10 ns edge must not load it.
    waitUntil(7);
    d = 1'b1;
    waitUntil(11);
    checkOutput("narrow_reset_hold_edge", {7'b0, q}, 8'h00);
    waitUntil(15);
    d = 1'b0;

    // Release the narrow reset with D = 0. D then toggles every 33 ns.
    waitUntil(20);
    rstN = 1'b1;
    waitUntil(31);
    checkOutput("narrow_capture_30", {7'b0, q}, 8'h00);
    waitUntil(53);
    d = 1'b1;
    waitUntil(71);
    checkOutput("narrow_capture_70", {7'b0, q}, 8'h01);

    // D changes mid-cycle. Q must hold until the 90 ns edge.
    waitUntil(86);
    d = 1'b0;
    waitUntil(89);
    checkOutput("narrow_hold_mid", {7'b0, q}, 8'h01);
    waitUntil(91);
    checkOutput("narrow_capture_90", {7'b0, q}, 8'h00);

    // Load D = 8'h3C into the wide instance while it is still in reset.
    waitUntil(100);
    wD = 8'h3C;
    waitUntil(119);
    d = 1'b1;
    waitUntil(131);
    checkOutput("narrow_capture_130", {7'b0, q}, 8'h01);

    // Reset mid-cycle with Q = 1. Q must clear at once and stay clear
    // while D = 1 and clock edges occur.
    waitUntil(135);
    rstN = 1'b0;
    waitUntil(136);
    checkOutput("narrow_async_clear", {7'b0, q}, 8'h00);
    waitUntil(151);
    checkOutput("narrow_reset_ignores_d", {7'b0, q}, 8'h00);
    waitUntil(171);
    checkOutput("wide_reset_hold", wQ, 8'hA5);

    // Release mid-cycle. Q keeps its reset value until the next rising
    // edge. The falling edge at 180 ns must not load D.
    waitUntil(175);
    rstN = 1'b1;
    waitUntil(176);
    checkOutput("narrow_release_hold", {7'b0, q}, 8'h00);
    waitUntil(181);
    checkOutput("narrow_falling_ignored", {7'b0, q}, 8'h00);
    waitUntil(191);
    checkOutput("narrow_capture_190", {7'b0, q}, 8'h01);

    // Release the wide reset. The first edge afterwards captures 8'h3C.
    waitUntil(195);
    wRstN = 1'b1;
    waitUntil(196);
    checkOutput("wide_release_hold", wQ, 8'hA5);
    waitUntil(211);
    checkOutput("wide_capture_3c", wQ, 8'h3C);

    // Drive back-to-back words. Each appears exactly one cycle later.
    waitUntil(215);
    wD = 8'h01;
    waitUntil(229);
    checkOutput("wide_hold_before_edge", wQ, 8'h3C);
    waitUntil(231);
    checkOutput("wide_b2b_01", wQ, 8'h01);
    waitUntil(235);
    wD = 8'hFF;
    waitUntil(251);
    checkOutput("wide_b2b_ff", wQ, 8'hFF);
    waitUntil(255);
    wD = 8'h00;
    waitUntil(271);
    checkOutput("wide_b2b_00", wQ, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
